// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the HI/LO multiply-divide unit and the main controller.
// Also holds the default latencies and the small decode helpers.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } xAluOp_e;

  typedef enum logic [1:0] {
    START_NONE   = 2'b00,
    START_LAUNCH = 2'b01,
    START_MOVE   = 2'b10,
    START_RSVD   = 2'b11
  } start_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mduState_e;

  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;

  function automatic logic isComputeOp(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic isDivOp(input logic [2:0] op);
    return (op[2:1] == 2'b01);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Results are computed from latched operands; the countdown FSM only models latency.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Start,
  input  logic [2:0]  XAluOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] Out
);

  mduState_e   state_r;
  mduState_e   nextState_s;
  logic [31:0] count_r;
  logic [31:0] nextCount_s;
  logic [31:0] opA_r;
  logic [31:0] opB_r;
  logic [2:0]  op_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic        launch_s;
  logic        commit_s;
  logic        moveHi_s;
  logic        moveLo_s;
  logic [31:0] resHi_s;
  logic [31:0] resLo_s;
  logic        resValid_s;

  logic [63:0] prodS_s;
  logic [63:0] prodU_s;
  logic [31:0] absA_s;
  logic [31:0] absB_s;
  logic [31:0] magQ_s;
  logic [31:0] magR_s;
  logic [31:0] quotS_s;
  logic [31:0] remS_s;
  logic [31:0] quotU_s;
  logic [31:0] remU_s;

  // Launch/move decode, countdown and next-state logic.
  always_comb begin
    launch_s    = 1'b0;
    commit_s    = 1'b0;
    moveHi_s    = 1'b0;
    moveLo_s    = 1'b0;
    nextState_s = state_r;
    nextCount_s = count_r;
    case (state_r)
      ST_IDLE: begin
        if (Start == START_LAUNCH && isComputeOp(XAluOp)) begin
          launch_s    = 1'b1;
          nextState_s = ST_RUN;
          nextCount_s = isDivOp(XAluOp) ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
        end else if (Start == START_MOVE && XAluOp == OP_MTHI) begin
          moveHi_s = 1'b1;
        end else if (Start == START_MOVE && XAluOp == OP_MTLO) begin
          moveLo_s = 1'b1;
        end else begin
          nextState_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (count_r == 32'd1) begin
          commit_s    = 1'b1;
          nextState_s = ST_IDLE;
          nextCount_s = 32'd0;
        end else begin
          nextCount_s = count_r - 32'd1;
        end
      end
      default: begin
        nextState_s = ST_IDLE;
        nextCount_s = 32'd0;
      end
    endcase
  end

  // Result arithmetic on the latched operands; signed division goes through
  // magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
  always_comb begin
    prodS_s = $signed({{32{opA_r[31]}}, opA_r}) * $signed({{32{opB_r[31]}}, opB_r});
    prodU_s = {32'd0, opA_r} * {32'd0, opB_r};
    absA_s  = opA_r[31] ? (32'd0 - opA_r) : opA_r;
    absB_s  = opB_r[31] ? (32'd0 - opB_r) : opB_r;
    if (opB_r != 32'd0) begin
      magQ_s  = absA_s / absB_s;
      magR_s  = absA_s % absB_s;
      quotU_s = opA_r / opB_r;
      remU_s  = opA_r % opB_r;
    end else begin
      magQ_s  = 32'd0;
      magR_s  = 32'd0;
      quotU_s = 32'd0;
      remU_s  = 32'd0;
    end
    quotS_s = (opA_r[31] ^ opB_r[31]) ? (32'd0 - magQ_s) : magQ_s;
    remS_s  = opA_r[31] ? (32'd0 - magR_s) : magR_s;
    case (op_r)
      OP_MULT: begin
        resHi_s    = prodS_s[63:32];
        resLo_s    = prodS_s[31:0];
        resValid_s = 1'b1;
      end
      OP_MULTU: begin
        resHi_s    = prodU_s[63:32];
        resLo_s    = prodU_s[31:0];
        resValid_s = 1'b1;
      end
      OP_DIV: begin
        resHi_s    = remS_s;
        resLo_s    = quotS_s;
        resValid_s = (opB_r != 32'd0);
      end
      OP_DIVU: begin
        resHi_s    = remU_s;
        resLo_s    = quotU_s;
        resValid_s = (opB_r != 32'd0);
      end
      default: begin
        resHi_s    = 32'd0;
        resLo_s    = 32'd0;
        resValid_s = 1'b0;
      end
    endcase
  end

  // State, countdown, operand latches and HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      count_r <= 32'd0;
      opA_r   <= 32'd0;
      opB_r   <= 32'd0;
      op_r    <= 3'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
    end else begin
      state_r <= nextState_s;
      count_r <= nextCount_s;
      if (launch_s) begin
        opA_r <= A;
        opB_r <= B;
        op_r  <= XAluOp;
      end
      if (commit_s && resValid_s) begin
        hi_r <= resHi_s;
        lo_r <= resLo_s;
      end else if (moveHi_s) begin
        hi_r <= A;
      end else if (moveLo_s) begin
        lo_r <= A;
      end
    end
  end

  assign Busy = (state_r == ST_RUN);

  // Read port shows committed HI/LO only.
  always_comb begin
    if (XAluOp == OP_MFHI) begin
      Out = hi_r;
    end else begin
      Out = lo_r;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed HI/LO values.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  Start;
  logic [2:0]  XAluOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] Out;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .XAluOp (XAluOp),
    .A      (A),
    .B      (B),
    .Busy   (Busy),
    .Out    (Out)
  );

  task automatic readHiLo(output logic [31:0] hi, output logic [31:0] lo);
    logic [2:0] saved;
    saved  = XAluOp;
    XAluOp = 3'd6;
    #1 hi  = Out;
    XAluOp = 3'd7;
    #1 lo  = Out;
    XAluOp = saved;
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Start = 2'b01; XAluOp = op; A = a; B = b;
    @(negedge clk);
    Start = 2'b00; A = 32'd0; B = 32'd0;
  endtask

  task automatic countBusy(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] hi, lo;
    reset = 1'b1; Start = 2'b00; XAluOp = 3'd7; A = 32'd0; B = 32'd0;
    repeat (2) @(negedge clk);
    readHiLo(hi, lo);
    vectors++;
    if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", Busy); end
    vectors++;
    if (hi !== 32'd0) begin miscompares++; $display("FAIL reset_hi got %h want 00000000", hi); end
    vectors++;
    if (lo !== 32'd0) begin miscompares++; $display("FAIL reset_lo got %h want 00000000", lo); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mult();
    logic [31:0] hi, lo;
    int n;
    launch(3'd0, 32'hFFFFFFFE, 32'd3);
    readHiLo(hi, lo);
    vectors++;
    if (lo !== 32'd0) begin miscompares++; $display("FAIL mult_inflight_lo got %h want 00000000", lo); end
    countBusy(n);
    vectors++;
    if (n != 5) begin miscompares++; $display("FAIL mult_busy got %0d want 5", n); end
    readHiLo(hi, lo);
    vectors++;
    if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    vectors++;
    if (lo !== 32'hFFFFFFFA) begin miscompares++; $display("FAIL mult_lo got %h want fffffffa", lo); end
  endtask

  task automatic test_multu();
    logic [31:0] hi, lo;
    int n;
    launch(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    countBusy(n);
    vectors++;
    if (n != 5) begin miscompares++; $display("FAIL multu_busy got %0d want 5", n); end
    readHiLo(hi, lo);
    vectors++;
    if (hi !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    vectors++;
    if (lo !== 32'h00000001) begin miscompares++; $display("FAIL multu_lo got %h want 00000001", lo); end
  endtask

  task automatic test_div();
    logic [31:0] hi, lo;
    int n;
    launch(3'd2, 32'hFFFFFFF9, 32'd2);
    countBusy(n);
    vectors++;
    if (n != 10) begin miscompares++; $display("FAIL div_busy got %0d want 10", n); end
    readHiLo(hi, lo);
    vectors++;
    if (lo !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL div_lo got %h want fffffffd", lo); end
    vectors++;
    if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL div_hi got %h want ffffffff", hi); end
    launch(3'd3, 32'd1234, 32'd0);
    countBusy(n);
    vectors++;
    if (n != 10) begin miscompares++; $display("FAIL divu0_busy got %0d want 10", n); end
    readHiLo(hi, lo);
    vectors++;
    if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL divu0_hi got %h want ffffffff", hi); end
    vectors++;
    if (lo !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL divu0_lo got %h want fffffffd", lo); end
  endtask

  task automatic test_div_corners();
    logic [31:0] hi, lo;
    int n;
    launch(3'd2, 32'h80000000, 32'hFFFFFFFF);
    countBusy(n);
    readHiLo(hi, lo);
    vectors++;
    if (lo !== 32'h80000000) begin miscompares++; $display("FAIL divovf_lo got %h want 80000000", lo); end
    vectors++;
    if (hi !== 32'd0) begin miscompares++; $display("FAIL divovf_hi got %h want 00000000", hi); end
    launch(3'd2, 32'd7, 32'hFFFFFFFE);
    countBusy(n);
    readHiLo(hi, lo);
    vectors++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'd1) begin
      miscompares++; $display("FAIL div_negdivisor got hi=%h lo=%h want hi=00000001 lo=fffffffd", hi, lo);
    end
    launch(3'd3, 32'd100, 32'd7);
    countBusy(n);
    readHiLo(hi, lo);
    vectors++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      miscompares++; $display("FAIL divu got hi=%h lo=%h want hi=00000002 lo=0000000e", hi, lo);
    end
  endtask

  task automatic test_move();
    logic [31:0] hi, lo;
    int n;
    @(negedge clk);
    Start = 2'b10; XAluOp = 3'd5; A = 32'h12345678;
    @(negedge clk);
    Start = 2'b00;
    vectors++;
    if (Busy !== 1'b0) begin miscompares++; $display("FAIL mtlo_busy got %b want 0", Busy); end
    XAluOp = 3'd7;
    #1;
    vectors++;
    if (Out !== 32'h12345678) begin miscompares++; $display("FAIL mflo got %h want 12345678", Out); end
    @(negedge clk);
    Start = 2'b10; XAluOp = 3'd4; A = 32'hCAFEF00D;
    @(negedge clk);
    Start = 2'b00;
    readHiLo(hi, lo);
    vectors++;
    if (hi !== 32'hCAFEF00D) begin miscompares++; $display("FAIL mthi got %h want cafef00d", hi); end
    // Illegal combinations must leave everything untouched.
    @(negedge clk);
    Start = 2'b01; XAluOp = 3'd5; A = 32'h1;
    @(negedge clk);
    Start = 2'b10; XAluOp = 3'd2; A = 32'h0000FFFF;
    vectors++;
    if (Busy !== 1'b0) begin miscompares++; $display("FAIL bad_launch_busy got %b want 0", Busy); end
    @(negedge clk);
    Start = 2'b11; XAluOp = 3'd0; A = 32'd5; B = 32'd5;
    @(negedge clk);
    Start = 2'b00;
    readHiLo(hi, lo);
    vectors++;
    if (Busy !== 1'b0 || hi !== 32'hCAFEF00D || lo !== 32'h12345678) begin
      miscompares++; $display("FAIL bad_start got busy=%b hi=%h lo=%h want busy=0 hi=cafef00d lo=12345678", Busy, hi, lo);
    end
    // MTHI and a second launch during MULT busy are ignored.
    launch(3'd0, 32'd3, 32'd4);
    Start = 2'b10; XAluOp = 3'd4; A = 32'hDEADBEEF;
    @(negedge clk);
    Start = 2'b01; XAluOp = 3'd3; A = 32'd1; B = 32'd1;
    @(negedge clk);
    Start = 2'b00;
    countBusy(n);
    n = n + 2;
    vectors++;
    if (n != 5) begin miscompares++; $display("FAIL busy_ignore_len got %0d want 5", n); end
    readHiLo(hi, lo);
    vectors++;
    if (hi !== 32'd0 || lo !== 32'd12) begin
      miscompares++; $display("FAIL busy_ignore_result got hi=%h lo=%h want hi=00000000 lo=0000000c", hi, lo);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] hi, lo;
    int n;
    launch(3'd2, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    vectors++;
    if (Busy !== 1'b1) begin miscompares++; $display("FAIL abort_prebusy got %b want 1", Busy); end
    reset = 1'b1;
    #1;
    vectors++;
    if (Busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", Busy); end
    readHiLo(hi, lo);
    vectors++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      miscompares++; $display("FAIL abort_hilo got hi=%h lo=%h want 0/0", hi, lo);
    end
    @(negedge clk);
    reset = 1'b0; Start = 2'b01; XAluOp = 3'd0; A = 32'd6; B = 32'd7;
    @(negedge clk);
    Start = 2'b00;
    vectors++;
    if (Busy !== 1'b1) begin miscompares++; $display("FAIL first_launch_busy got %b want 1", Busy); end
    countBusy(n);
    vectors++;
    if (n != 5) begin miscompares++; $display("FAIL post_reset_busy got %0d want 5", n); end
    readHiLo(hi, lo);
    vectors++;
    if (hi !== 32'd0 || lo !== 32'd42) begin
      miscompares++; $display("FAIL post_reset_mult got hi=%h lo=%h want hi=00000000 lo=0000002a", hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_corners();
    test_move();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have the parameter MULT_CYCLES, default 5, meaning the busy length of MULT/MULTU in cycles.
REQ-002 The block SHALL have the parameter DIV_CYCLES, default 10, meaning the busy length of DIV/DIVU in cycles.
REQ-003 The block SHALL have the port clk  input  1  single clock, rising edge.
REQ-004 The block SHALL have the port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have the port Start  input  2  00 none, 01 launch computation, 10 move-to HI/LO, 11 treated as 00.
REQ-006 The block SHALL have the port XAluOp  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
REQ-007 The block SHALL have the port A  input  32  rs operand.
REQ-008 The block SHALL have the port B  input  32  rt operand.
REQ-009 The block SHALL have the port Busy  output  1  computation in progress.
REQ-010 The block SHALL have the port Out  output  32  HI when XAluOp==6, else LO (combinational).

Function
REQ-011 The block SHALL sample A, B and XAluOp at the rising edge where Start==01 and Busy==0, with XAluOp in 0..3.
REQ-012 After a launch, Busy SHALL be 1 for exactly N consecutive cycles, N = MULT_CYCLES (ops 0/1) or DIV_CYCLES (ops 2/3), starting the cycle after the launch edge.
REQ-013 HI/LO SHALL update at the edge ending the last busy cycle, so the new values are visible when Busy returns to 0.
REQ-014 MULT SHALL produce the signed 64-bit product; MULTU SHALL produce the unsigned product; HI SHALL receive bits 63:32 and LO bits 31:0.
REQ-015 DIV SHALL be signed: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
REQ-016 DIVU SHALL be unsigned: LO = quotient, HI = remainder.
REQ-017 DIV/DIVU with B==0 SHALL still assert Busy for DIV_CYCLES and SHALL leave HI and LO unchanged.
REQ-018 DIV with 0x80000000 / 0xFFFFFFFF SHALL produce LO=0x80000000 and HI=0.
REQ-019 Start==10 with Busy==0 SHALL write A to HI (op 4) or LO (op 5) at that edge, with no Busy assertion.
REQ-020 Any Start!=00 while Busy==1 SHALL be ignored; operands and the countdown SHALL be unaffected.
REQ-021 Start==01 with XAluOp outside 0..3, or Start==10 with XAluOp outside 4..5, SHALL be ignored.
REQ-022 Out SHALL reflect committed HI/LO only; in-flight results SHALL never appear on Out before commit.
REQ-023 The block SHALL use a two-state FSM: IDLE --(valid launch)--> RUN; RUN --(count==1)--> IDLE with commit; the count SHALL load N at launch and decrement by 1 each RUN cycle.
REQ-024 A valid launch and a commit SHALL never coincide, because a launch requires Busy==0.

Reset
REQ-025 When reset is asserted, asynchronously: HI=0, LO=0, Busy=0, count=0, FSM=IDLE, latched operands=0.
REQ-026 Reset asserted mid-computation SHALL abort the operation with no commit; Out SHALL be 0 on the next read.
REQ-027 The first launch SHALL be accepted at the first rising edge after reset deasserts.

Structure
REQ-028 The XAluOp encodings, the Start encodings and the default MULT_CYCLES/DIV_CYCLES values SHALL live in the shared package also used by the main controller.
REQ-029 The result arithmetic SHALL use behavioural * and / / % on latched operands; only the count/FSM SHALL model the latency; no sub-module is required.

Verification
REQ-030 MULT A=0xFFFFFFFE (-2), B=3 -> Busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles, HI=0xFFFFFFFE, LO=0x00000001.
REQ-032 DIV A=-7, B=2 -> Busy for 10 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU with B=0 afterwards -> Busy for 10 cycles, HI/LO unchanged.
REQ-033 MTLO A=0x12345678 -> LO=0x12345678 at the next edge with Busy never set; MFLO -> Out=0x12345678; an MTHI issued during a following MULT's Busy window -> ignored.
REQ-034 Launch DIV, assert reset in busy cycle 4 -> Busy=0 immediately, HI=LO=0, no later commit; a new MULT 6*7 -> LO=42, HI=0.
